ecc_secded_decoder_pipe: RTL and testbench

Pipelined, parametrised SECDED Hamming decoder with valid/ready flow control, a full error classification, and saturating error-event counters. It is the streaming successor to the combinational ECC decoder and sits on the read return path of ECC-protected memories, between the array output register and the requester. It corrects single-bit errors, flags double-bit and out-of-range errors, and leaves uncorrectable data unmodified.

---
 rtl/ecc_secded_decoder_pipe_if.sv | 31 +++
 rtl/ecc_secded_decoder_pipe.sv | 144 ++++++++++++++
 tb/tb_ecc_secded_decoder_pipe.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_secded_decoder_pipe_if.sv
// Streaming port bundle for the pipelined SECDED decoder: input/output handshakes,
// decode results and the error-event counters.
interface ecc_secded_decoder_pipe_if #(
  parameter int unsigned data_bit_width      = 64,
  parameter int unsigned redundant_bit_width = 8,
  parameter int unsigned cnt_width           = 16
);
  localparam int unsigned code_width = data_bit_width + redundant_bit_width;

  logic                           in_valid;
  logic                           in_ready;
  logic [code_width-1:0]          in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [data_bit_width-1:0]      out_data;
  logic [1:0]                     out_err;
  logic [redundant_bit_width-2:0] out_syndrome;
  logic                           cnt_clr;
  logic [cnt_width-1:0]           cnt_corr;
  logic [cnt_width-1:0]           cnt_uncorr;

  modport master (
    output in_valid, in_data, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, out_err, out_syndrome, cnt_corr, cnt_uncorr
  );

  modport slave (
    input  in_valid, in_data, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, out_err, out_syndrome, cnt_corr, cnt_uncorr
  );
endinterface

// File: rtl/ecc_secded_decoder_pipe.sv
// Two-stage SECDED Hamming decoder: S1 registers codeword/syndrome/parity, S2 classifies,
// corrects and registers the result. Saturating counters track corrected/uncorrectable words.
module ecc_secded_decoder_pipe #(
  parameter int unsigned data_bit_width      = 64,
  parameter int unsigned redundant_bit_width = 8,
  parameter int unsigned cnt_width           = 16
) (
  input logic                      clk,
  input logic                      rst,
  ecc_secded_decoder_pipe_if.slave bus
);
  localparam int unsigned code_width = data_bit_width + redundant_bit_width;
  localparam int unsigned syn_width  = redundant_bit_width - 1;

  // k-th non-power-of-two position at index >= 3
  function automatic int unsigned data_pos(int unsigned k);
    int unsigned pos;
    int unsigned cnt;
    pos = 3;
    cnt = 0;
    for (int unsigned i = 3; i < code_width; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == k) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic                      s1_valid_q;
  logic [code_width-1:0]     s1_code_q;
  logic [syn_width-1:0]      s1_syn_q;
  logic                      s1_par_q;
  logic                      out_valid_q;
  logic [data_bit_width-1:0] out_data_q;
  logic [1:0]                out_err_q;
  logic [syn_width-1:0]      out_syn_q;
  logic [cnt_width-1:0]      cnt_corr_q;
  logic [cnt_width-1:0]      cnt_uncorr_q;

  logic                      s1_adv;
  logic                      s2_adv;
  logic [syn_width-1:0]      in_syn;
  logic                      in_par;
  logic [code_width-1:0]     flip_mask;
  logic [code_width-1:0]     fixed;
  logic [1:0]                err;
  logic [data_bit_width-1:0] data;
  logic                      hs;

  assign s2_adv      = !out_valid_q || bus.out_ready;
  assign s1_adv      = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  always_comb begin
    in_syn = '0;
    for (int unsigned i = 1; i < code_width; i++) begin
      if (bus.in_data[i]) in_syn ^= syn_width'(i);
    end
    in_par = ^bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_code_q <= bus.in_data;
        s1_syn_q  <= in_syn;
        s1_par_q  <= in_par;
      end
    end
  end

  for (genvar i = 0; i < code_width; i++) begin : g_flip
    assign flip_mask[i] = (i != 0) && (s1_syn_q == syn_width'(i));
  end

  always_comb begin
    fixed = s1_code_q;
    err   = 2'b00;
    if (!s1_par_q) begin
      err = (s1_syn_q == '0) ? 2'b00 : 2'b10;
    end else if (s1_syn_q == '0) begin
      err = 2'b01;
    end else if (32'(s1_syn_q) < code_width) begin
      err   = 2'b01;
      fixed = s1_code_q ^ flip_mask;
    end else begin
      err = 2'b11;
    end
  end

  for (genvar k = 0; k < data_bit_width; k++) begin : g_extract
    assign data[k] = fixed[data_pos(k)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 2'b00;
      out_syn_q   <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= data;
        out_err_q  <= err;
        out_syn_q  <= s1_syn_q;
      end
    end
  end

  assign hs = out_valid_q && bus.out_ready;

  // Clear wins over a coincident counted event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      if (hs && (out_err_q == 2'b01) && !(&cnt_corr_q)) begin
        cnt_corr_q <= cnt_corr_q + cnt_width'(1);
      end
      if (hs && out_err_q[1] && !(&cnt_uncorr_q)) begin
        cnt_uncorr_q <= cnt_uncorr_q + cnt_width'(1);
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_err      = out_err_q;
  assign bus.out_syndrome = out_syn_q;
  assign bus.cnt_corr     = cnt_corr_q;
  assign bus.cnt_uncorr   = cnt_uncorr_q;
endmodule

// File: tb/tb_ecc_secded_decoder_pipe.sv
// Bench for ecc_secded_decoder_pipe: a 4+4 bit instance with 2-bit counters and a 64+8
// instance, checked against a rule-level model through per-instance expectation queues.
module tb_ecc_secded_decoder_pipe;
  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  err;
    logic [31:0] syn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecc_secded_decoder_pipe_if #(.data_bit_width(4), .redundant_bit_width(4), .cnt_width(2)) bus_s ();
  ecc_secded_decoder_pipe_if #(.data_bit_width(64), .redundant_bit_width(8), .cnt_width(16)) bus_b ();

  ecc_secded_decoder_pipe #(
    .data_bit_width(4), .redundant_bit_width(4), .cnt_width(2)
  ) u_dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  ecc_secded_decoder_pipe #(
    .data_bit_width(64), .redundant_bit_width(8), .cnt_width(16)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;
  exp_t q_s[$], q_b[$], dir_s[$], dir_b[$];
  int corr_s = 0, unc_s = 0, corr_b = 0, unc_b = 0;
  bit acc_s, acc_b;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] d, input logic [1:0] e, input int s);
    exp_t r;
    r.data = d;
    r.err  = e;
    r.syn  = s;
    return r;
  endfunction

  // Decode by the rules: even parity, syndrome = XOR of set-bit indices.
  function automatic exp_t model(input logic [127:0] cw, input int n);
    exp_t r;
    int s, k;
    bit p;
    logic [127:0] c;
    s = 0; p = 0; c = cw; k = 0;
    for (int i = 0; i < n; i++) if (cw[i]) begin p = ~p; s = s ^ i; end
    if (!p) r.err = (s == 0) ? 2'b00 : 2'b10;
    else if (s == 0) r.err = 2'b01;
    else if (s < n) begin r.err = 2'b01; c[s] = ~c[s]; end
    else r.err = 2'b11;
    r.data = '0;
    for (int i = 3; i < n; i++) if ((i & (i - 1)) != 0) begin r.data[k] = c[i]; k++; end
    r.syn = s;
    return r;
  endfunction

  function automatic logic [127:0] encode72(input logic [63:0] d);
    logic [127:0] cw;
    int k, s;
    cw = '0; k = 0; s = 0;
    for (int i = 3; i < 72; i++) if ((i & (i - 1)) != 0) begin cw[i] = d[k]; k++; end
    for (int i = 1; i < 72; i++) if (cw[i]) s = s ^ i;
    for (int j = 0; j < 7; j++) if (((s >> j) & 1) != 0) cw[1 << j] = 1'b1;
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [127:0] rand_big();
    logic [127:0] cw;
    int nf;
    cw = encode72({$urandom, $urandom});
    nf = $urandom_range(0, 3);
    for (int f = 0; f < nf; f++) cw[$urandom_range(0, 71)] ^= 1'b1;
    return cw;
  endfunction

  function automatic int cnt_next(input int c, input bit clr, input bit ev, input int maxv);
    if (clr) return 0;
    if (ev && c < maxv) return c + 1;
    return c;
  endfunction

  // Inputs are set 1 time unit after a rising edge; handshakes are sampled 3 units later.
  task automatic cycle();
    exp_t e;
    bit hs_s, hs_b, clr_s, clr_b;
    logic [1:0] er_s, er_b;
    #3;
    hs_s = 0; hs_b = 0; er_s = 0; er_b = 0;
    if (q_s.size() == 0) check("s_idle_valid", 128'(bus_s.out_valid), 0);
    if (bus_s.out_valid && bus_s.out_ready && q_s.size() > 0) begin
      e = q_s.pop_front();
      check("s_data", 128'(bus_s.out_data), 128'(e.data));
      check("s_err", 128'(bus_s.out_err), 128'(e.err));
      check("s_syn", 128'(bus_s.out_syndrome), 128'(e.syn));
      hs_s = 1; er_s = e.err;
    end
    acc_s = bus_s.in_valid && bus_s.in_ready;
    if (acc_s) begin
      if (dir_s.size() > 0) q_s.push_back(dir_s.pop_front());
      else q_s.push_back(model(128'(bus_s.in_data), 8));
    end
    if (q_b.size() == 0) check("b_idle_valid", 128'(bus_b.out_valid), 0);
    if (bus_b.out_valid && bus_b.out_ready && q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_data", 128'(bus_b.out_data), 128'(e.data));
      check("b_err", 128'(bus_b.out_err), 128'(e.err));
      check("b_syn", 128'(bus_b.out_syndrome), 128'(e.syn));
      hs_b = 1; er_b = e.err;
    end
    acc_b = bus_b.in_valid && bus_b.in_ready;
    if (acc_b) begin
      if (dir_b.size() > 0) q_b.push_back(dir_b.pop_front());
      else q_b.push_back(model(128'(bus_b.in_data), 72));
    end
    clr_s = bus_s.cnt_clr;
    clr_b = bus_b.cnt_clr;
    @(posedge clk);
    #1;
    corr_s = cnt_next(corr_s, clr_s, hs_s && er_s == 2'b01, 3);
    unc_s  = cnt_next(unc_s, clr_s, hs_s && er_s[1], 3);
    corr_b = cnt_next(corr_b, clr_b, hs_b && er_b == 2'b01, 65535);
    unc_b  = cnt_next(unc_b, clr_b, hs_b && er_b[1], 65535);
    check("s_cnt_corr", 128'(bus_s.cnt_corr), 128'(corr_s));
    check("s_cnt_uncorr", 128'(bus_s.cnt_uncorr), 128'(unc_s));
    check("b_cnt_corr", 128'(bus_b.cnt_corr), 128'(corr_b));
    check("b_cnt_uncorr", 128'(bus_b.cnt_uncorr), 128'(unc_b));
  endtask

  task automatic send_s(input logic [7:0] w);
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = w;
    cycle();
    bus_s.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [71:0] w);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = w;
    cycle();
    bus_b.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  bp_words [4];
    logic [63:0] d;
    logic [127:0] cw;
    exp_t        e0;
    int          idx;

    bus_s.in_valid = 0; bus_s.in_data = '0; bus_s.out_ready = 1; bus_s.cnt_clr = 0;
    bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.out_ready = 1; bus_b.cnt_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 128'(bus_s.out_valid), 0);
    check("rst_out_data", 128'(bus_s.out_data), 0);
    check("rst_out_err", 128'(bus_s.out_err), 0);
    check("rst_out_syn", 128'(bus_s.out_syndrome), 0);
    check("rst_cnt_corr", 128'(bus_s.cnt_corr), 0);
    check("rst_cnt_uncorr", 128'(bus_b.cnt_uncorr), 0);
    check("rst_in_ready_s", 128'(bus_s.in_ready), 1);
    check("rst_in_ready_b", 128'(bus_b.in_ready), 1);

    // Two-stage latency on a clean word.
    dir_s.push_back(mk(64'hB, 2'b00, 0));
    send_s(8'hAA);
    check("lat_after_edge1", 128'(bus_s.out_valid), 0);
    cycle();
    check("lat_after_edge2", 128'(bus_s.out_valid), 1);
    check("lat_data", 128'(bus_s.out_data), 128'(4'b1011));
    cycle();

    dir_s.push_back(mk(64'hB, 2'b01, 5));
    dir_s.push_back(mk(64'hB, 2'b01, 0));
    dir_s.push_back(mk(64'hE, 2'b10, 5));
    send_s(8'h8A);
    send_s(8'hAB);
    send_s(8'hE2);
    repeat (3) cycle();
    check("cnt_corr_two", 128'(bus_s.cnt_corr), 2);
    check("cnt_uncorr_one", 128'(bus_s.cnt_uncorr), 1);

    d  = {$urandom, $urandom};
    cw = encode72(d);
    dir_b.push_back(mk(d, 2'b00, 0));
    dir_b.push_back(mk(d, 2'b01, 65));
    dir_b.push_back(mk(64'h0, 2'b11, 74));
    send_b(cw[71:0]);
    send_b(cw[71:0] ^ (72'(1) << 65));
    send_b((72'(1) << 64) | (72'(1) << 8) | (72'(1) << 2));
    repeat (3) cycle();

    for (int c = 0; c < 300; c++) begin
      bus_s.in_valid  = ($urandom_range(0, 3) != 0);
      bus_s.in_data   = 8'($urandom);
      bus_s.out_ready = ($urandom_range(0, 2) != 0);
      bus_s.cnt_clr   = ($urandom_range(0, 31) == 0);
      cw = rand_big();
      bus_b.in_valid  = ($urandom_range(0, 3) != 0);
      bus_b.in_data   = cw[71:0];
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
      bus_b.cnt_clr   = ($urandom_range(0, 31) == 0);
      cycle();
    end
    bus_s.in_valid = 0; bus_s.out_ready = 1; bus_s.cnt_clr = 0;
    bus_b.in_valid = 0; bus_b.out_ready = 1; bus_b.cnt_clr = 0;
    repeat (4) cycle();

    // Backpressure: 4 words, 5 stalled cycles.
    bp_words[0] = 8'hAA; bp_words[1] = 8'h8A; bp_words[2] = 8'hE2; bp_words[3] = 8'hAB;
    e0 = model(128'(bp_words[0]), 8);
    idx = 0;
    bus_s.out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      bus_s.in_valid = (idx < 4);
      bus_s.in_data  = bp_words[idx % 4];
      if (c >= 2) begin
        check("bp_in_ready_low", 128'(bus_s.in_ready), 0);
        check("bp_hold_valid", 128'(bus_s.out_valid), 1);
        check("bp_hold_data", 128'(bus_s.out_data), 128'(e0.data));
        check("bp_hold_err", 128'(bus_s.out_err), 128'(e0.err));
      end
      cycle();
      if (acc_s) idx++;
    end
    check("bp_accepted_two", 128'(idx), 2);
    bus_s.out_ready = 1;
    for (int c = 0; c < 20 && (idx < 4 || q_s.size() > 0); c++) begin
      bus_s.in_valid = (idx < 4);
      bus_s.in_data  = bp_words[idx % 4];
      cycle();
      if (acc_s) idx++;
    end
    bus_s.in_valid = 0;
    check("bp_all_sent", 128'(idx), 4);
    check("bp_drained", 128'(q_s.size()), 0);

    // Saturation of the 2-bit corrected counter.
    bus_s.cnt_clr = 1;
    cycle();
    bus_s.cnt_clr = 0;
    repeat (5) send_s(8'h8A);
    repeat (3) cycle();
    check("cnt_sat", 128'(bus_s.cnt_corr), 3);

    // Clear coinciding with a corrected handshake.
    bus_s.out_ready = 0;
    send_s(8'hAB);
    for (int c = 0; c < 5 && !bus_s.out_valid; c++) cycle();
    check("clr_word_ready", 128'(bus_s.out_valid), 1);
    bus_s.out_ready = 1;
    bus_s.cnt_clr   = 1;
    cycle();
    bus_s.cnt_clr = 0;
    check("cnt_clr_prio", 128'(bus_s.cnt_corr), 0);

    // Reset with two words in flight in each instance.
    bus_s.out_ready = 0; bus_b.out_ready = 0;
    for (int c = 0; c < 2; c++) begin
      bus_s.in_valid = 1; bus_s.in_data = (c == 0) ? 8'h8A : 8'hE2;
      cw = rand_big();
      bus_b.in_valid = 1; bus_b.in_data = cw[71:0];
      cycle();
    end
    bus_s.in_valid = 0; bus_b.in_valid = 0;
    check("pre_rst_full_s", 128'(bus_s.in_ready), 0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid_s", 128'(bus_s.out_valid), 0);
    check("rst_mid_valid_b", 128'(bus_b.out_valid), 0);
    q_s.delete(); q_b.delete(); dir_s.delete(); dir_b.delete();
    corr_s = 0; unc_s = 0; corr_b = 0; unc_b = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_cnt_s", 128'(bus_s.cnt_corr), 0);
    check("rst_mid_cnt_b", 128'(bus_b.cnt_uncorr), 0);
    bus_s.out_ready = 1; bus_b.out_ready = 1;
    repeat (6) cycle();

    check("final_q_s", 128'(q_s.size()), 0);
    check("final_q_b", 128'(q_b.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
